// File: rtl/rpn_stack_controller_pkg.sv
// Shared definitions for the RPN calculator: sizes, sequencer states,
// ULA opcodes and display base codes.
package rpn_stack_controller_pkg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        BUSCA   = 2'd1,
        ESPERA  = 2'd2,
        ESCREVE = 2'd3
    } estado_t;

    localparam logic [2:0] OP_SOMA = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_E    = 3'd2;
    localparam logic [2:0] OP_OU   = 3'd3;
    localparam logic [2:0] OP_XOU  = 3'd4;
    localparam logic [2:0] OP_NAO  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;

    localparam logic [1:0] BASE_DEC = 2'b00;
    localparam logic [1:0] BASE_HEX = 2'b01;
    localparam logic [1:0] BASE_OCT = 2'b10;

endpackage

// File: rtl/rpn_stack_controller_if.sv
// Bundle between the RPN stack controller, the switches/buttons,
// the combinational ULA and the display stage.
interface rpn_stack_controller_if;
    import rpn_stack_controller_pkg::*;

    logic [WIDTH-1:0] Entrada;
    logic             Enter;
    logic             Operar;
    logic             Limpar;
    logic [2:0]       Opcode;
    logic [1:0]       BaseSel;
    logic [WIDTH-1:0] ResultadoULA;
    logic [WIDTH-1:0] OperandoA;
    logic [WIDTH-1:0] OperandoB;
    logic [2:0]       OpcodeULA;
    logic [WIDTH-1:0] Resultado;
    logic [1:0]       Base;
    logic [CNT_W-1:0] Nivel;
    logic             Ocupado;
    logic             Erro;

    modport slave (
        input  Entrada, Enter, Operar, Limpar, Opcode, BaseSel, ResultadoULA,
        output OperandoA, OperandoB, OpcodeULA, Resultado, Base, Nivel, Ocupado, Erro
    );

    modport master (
        output Entrada, Enter, Operar, Limpar, Opcode, BaseSel, ResultadoULA,
        input  OperandoA, OperandoB, OpcodeULA, Resultado, Base, Nivel, Ocupado, Erro
    );

endinterface

// File: rtl/rpn_stack_controller_detectorBorda.sv
// Rising-edge detector for one button level: one pulse per press.
module rpn_stack_controller_detectorBorda (
    input  logic Clock,
    input  logic Reset_n,
    input  logic nivelIn,
    output logic evento
);

    logic anterior;

    // History of the button level, cleared by reset.
    always_ff @(posedge Clock) begin
        if (!Reset_n) anterior <= 1'b0;
        else          anterior <= nivelIn;
    end

    assign evento = nivelIn & ~anterior;

endmodule

// File: rtl/rpn_stack_controller.sv
// Operand stack and operate sequencer for the 8-bit RPN calculator.
//
//  state   | meaning
//  OCIOSO  | idle; accepts clear, operate and push events
//  BUSCA   | register the two top operands toward the ULA
//  ESPERA  | ULA settles on the registered operands
//  ESCREVE | write ULA result into stack[top-1], drop one level
module rpn_stack_controller
    import rpn_stack_controller_pkg::*;
(
    input logic Clock,
    input logic Reset_n,
    rpn_stack_controller_if.slave bus
);

    estado_t          estado, estadoProx;
    logic [WIDTH-1:0] pilha [DEPTH];
    logic [CNT_W-1:0] nivel;
    logic [WIDTH-1:0] operandoA, operandoB;
    logic [2:0]       opcodeUla;
    logic [1:0]       base;
    logic             ocupado, erro;
    logic             evEnter, evOperar, evLimpar;
    logic             limpa, empilha, iniciaOp, busca, escreve, setErro;
    logic [PTR_W-1:0] topo, abaixo;

    rpn_stack_controller_detectorBorda uBordaEnter (
        .Clock(Clock), .Reset_n(Reset_n), .nivelIn(bus.Enter), .evento(evEnter)
    );
    rpn_stack_controller_detectorBorda uBordaOperar (
        .Clock(Clock), .Reset_n(Reset_n), .nivelIn(bus.Operar), .evento(evOperar)
    );
    rpn_stack_controller_detectorBorda uBordaLimpar (
        .Clock(Clock), .Reset_n(Reset_n), .nivelIn(bus.Limpar), .evento(evLimpar)
    );

    assign topo   = PTR_W'(nivel - CNT_W'(1));
    assign abaixo = PTR_W'(nivel - CNT_W'(2));

    // State register; Ocupado is registered from the next state.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            estado  <= OCIOSO;
            ocupado <= 1'b0;
        end else begin
            estado  <= estadoProx;
            ocupado <= (estadoProx != OCIOSO);
        end
    end

    // Next state and one-cycle datapath strobes; events outside OCIOSO are dropped.
    always_comb begin
        estadoProx = estado;
        limpa      = 1'b0;
        empilha    = 1'b0;
        iniciaOp   = 1'b0;
        busca      = 1'b0;
        escreve    = 1'b0;
        setErro    = 1'b0;
        case (estado)
            OCIOSO: begin
                if (evLimpar) begin
                    limpa = 1'b1;
                end else if (evOperar) begin
                    if (nivel < CNT_W'(2)) begin
                        setErro = 1'b1;
                    end else begin
                        iniciaOp   = 1'b1;
                        estadoProx = BUSCA;
                    end
                end else if (evEnter) begin
                    if (nivel == CNT_W'(DEPTH)) setErro = 1'b1;
                    else                        empilha = 1'b1;
                end
            end
            BUSCA: begin
                busca      = 1'b1;
                estadoProx = ESPERA;
            end
            ESPERA: begin
                estadoProx = ESCREVE;
            end
            ESCREVE: begin
                escreve    = 1'b1;
                estadoProx = OCIOSO;
            end
            default: estadoProx = OCIOSO;
        endcase
    end

    // Stack storage, level counter, ULA operand registers and flags.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) pilha[i] <= '0;
            nivel     <= '0;
            operandoA <= '0;
            operandoB <= '0;
            opcodeUla <= '0;
            base      <= '0;
            erro      <= 1'b0;
        end else begin
            base <= bus.BaseSel;
            if (setErro) erro <= 1'b1;
            if (limpa) begin
                for (int i = 0; i < DEPTH; i++) pilha[i] <= '0;
                nivel <= '0;
                erro  <= 1'b0;
            end
            if (empilha) begin
                pilha[PTR_W'(nivel)] <= bus.Entrada;
                nivel                <= nivel + CNT_W'(1);
            end
            if (iniciaOp) opcodeUla <= bus.Opcode;
            if (busca) begin
                operandoA <= pilha[abaixo];
                operandoB <= pilha[topo];
            end
            if (escreve) begin
                pilha[abaixo] <= bus.ResultadoULA;
                nivel         <= nivel - CNT_W'(1);
            end
        end
    end

    assign bus.Resultado = (nivel == '0) ? '0 : pilha[topo];
    assign bus.OperandoA = operandoA;
    assign bus.OperandoB = operandoB;
    assign bus.OpcodeULA = opcodeUla;
    assign bus.Base      = base;
    assign bus.Nivel     = nivel;
    assign bus.Ocupado   = ocupado;
    assign bus.Erro      = erro;

endmodule

// File: tb/tb_rpn_stack_controller.sv
// Directed bench for the RPN stack controller with a reference ULA model.
module tb_rpn_stack_controller;
    import rpn_stack_controller_pkg::*;

    logic Clock;
    logic Reset_n;
    int   vectors;
    int   miscompares;
    logic [WIDTH-1:0] ulaRes;

    rpn_stack_controller_if bus ();

    rpn_stack_controller dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .bus(bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference combinational ULA.
    always_comb begin
        case (bus.OpcodeULA)
            OP_SOMA: ulaRes = bus.OperandoA + bus.OperandoB;
            OP_SUB:  ulaRes = bus.OperandoA - bus.OperandoB;
            OP_E:    ulaRes = bus.OperandoA & bus.OperandoB;
            OP_OU:   ulaRes = bus.OperandoA | bus.OperandoB;
            OP_XOU:  ulaRes = bus.OperandoA ^ bus.OperandoB;
            OP_NAO:  ulaRes = ~bus.OperandoA;
            OP_MUL:  ulaRes = bus.OperandoA * bus.OperandoB;
            default: ulaRes = '0;
        endcase
    end
    assign bus.ResultadoULA = ulaRes;

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        bus.Entrada = v;
        bus.Enter   = 1'b1;
        step(1);
        bus.Enter   = 1'b0;
        step(1);
    endtask

    task automatic pulse_limpar();
        bus.Limpar = 1'b1;
        step(1);
        bus.Limpar = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        step(2);
        Reset_n = 1'b1;
        vectors++; if (bus.Nivel !== 3'd0) begin miscompares++; $display("FAIL reset_nivel: got %0d expected 0", bus.Nivel); end
        vectors++; if (bus.Resultado !== 8'd0) begin miscompares++; $display("FAIL reset_resultado: got %0d expected 0", bus.Resultado); end
        vectors++; if (bus.Ocupado !== 1'b0) begin miscompares++; $display("FAIL reset_ocupado: got %b expected 0", bus.Ocupado); end
        vectors++; if (bus.Erro !== 1'b0) begin miscompares++; $display("FAIL reset_erro: got %b expected 0", bus.Erro); end
        vectors++; if (bus.OperandoA !== 8'd0 || bus.OperandoB !== 8'd0) begin miscompares++; $display("FAIL reset_operandos: got %0d/%0d expected 0/0", bus.OperandoA, bus.OperandoB); end
    endtask

    task automatic test_push();
        push(8'd12);
        push(8'd30);
        vectors++; if (bus.Nivel !== 3'd2) begin miscompares++; $display("FAIL push_nivel: got %0d expected 2", bus.Nivel); end
        vectors++; if (bus.Resultado !== 8'd30) begin miscompares++; $display("FAIL push_resultado: got %0d expected 30", bus.Resultado); end
        vectors++; if (bus.Erro !== 1'b0) begin miscompares++; $display("FAIL push_erro: got %b expected 0", bus.Erro); end
    endtask

    task automatic test_operate_soma();
        bus.Opcode = OP_SOMA;
        bus.Operar = 1'b1;
        step(1);
        vectors++; if (bus.Ocupado !== 1'b1) begin miscompares++; $display("FAIL soma_ocupado_n1: got %b expected 1", bus.Ocupado); end
        vectors++; if (bus.Nivel !== 3'd2) begin miscompares++; $display("FAIL soma_nivel_n1: got %0d expected 2", bus.Nivel); end
        bus.Operar = 1'b0;
        step(1);
        vectors++; if (bus.Ocupado !== 1'b1) begin miscompares++; $display("FAIL soma_ocupado_n2: got %b expected 1", bus.Ocupado); end
        vectors++; if (bus.OperandoA !== 8'd12 || bus.OperandoB !== 8'd30) begin miscompares++; $display("FAIL soma_operandos: got %0d/%0d expected 12/30", bus.OperandoA, bus.OperandoB); end
        vectors++; if (bus.OpcodeULA !== OP_SOMA) begin miscompares++; $display("FAIL soma_opcode: got %0d expected %0d", bus.OpcodeULA, OP_SOMA); end
        step(1);
        vectors++; if (bus.Ocupado !== 1'b1) begin miscompares++; $display("FAIL soma_ocupado_n3: got %b expected 1", bus.Ocupado); end
        vectors++; if (bus.Resultado !== 8'd30) begin miscompares++; $display("FAIL soma_resultado_n3: got %0d expected 30", bus.Resultado); end
        step(1);
        vectors++; if (bus.Ocupado !== 1'b0) begin miscompares++; $display("FAIL soma_ocupado_n4: got %b expected 0", bus.Ocupado); end
        vectors++; if (bus.Resultado !== 8'd42) begin miscompares++; $display("FAIL soma_resultado: got %0d expected 42", bus.Resultado); end
        vectors++; if (bus.Nivel !== 3'd1) begin miscompares++; $display("FAIL soma_nivel: got %0d expected 1", bus.Nivel); end
    endtask

    task automatic test_sub_underflow();
        pulse_limpar();
        push(8'd200);
        push(8'd100);
        bus.Opcode = OP_SUB;
        bus.Operar = 1'b1;
        step(1);
        bus.Operar = 1'b0;
        step(3);
        vectors++; if (bus.Resultado !== 8'd100) begin miscompares++; $display("FAIL sub_resultado: got %0d expected 100", bus.Resultado); end
        vectors++; if (bus.Nivel !== 3'd1) begin miscompares++; $display("FAIL sub_nivel: got %0d expected 1", bus.Nivel); end
        bus.Operar = 1'b1;
        step(1);
        vectors++; if (bus.Ocupado !== 1'b0) begin miscompares++; $display("FAIL underflow_ocupado: got %b expected 0", bus.Ocupado); end
        vectors++; if (bus.Erro !== 1'b1) begin miscompares++; $display("FAIL underflow_erro: got %b expected 1", bus.Erro); end
        bus.Operar = 1'b0;
        step(1);
        vectors++; if (bus.Resultado !== 8'd100 || bus.Nivel !== 3'd1) begin miscompares++; $display("FAIL underflow_stack: got %0d/%0d expected 100/1", bus.Resultado, bus.Nivel); end
        push(8'd7);
        vectors++; if (bus.Erro !== 1'b1 || bus.Nivel !== 3'd2) begin miscompares++; $display("FAIL erro_sticky: got erro %b nivel %0d expected 1/2", bus.Erro, bus.Nivel); end
    endtask

    task automatic test_overflow_limpar();
        pulse_limpar();
        for (int i = 1; i <= 4; i++) push(8'(i));
        vectors++; if (bus.Nivel !== 3'd4 || bus.Erro !== 1'b0) begin miscompares++; $display("FAIL full_stack: got nivel %0d erro %b expected 4/0", bus.Nivel, bus.Erro); end
        push(8'd5);
        vectors++; if (bus.Erro !== 1'b1) begin miscompares++; $display("FAIL overflow_erro: got %b expected 1", bus.Erro); end
        vectors++; if (bus.Nivel !== 3'd4) begin miscompares++; $display("FAIL overflow_nivel: got %0d expected 4", bus.Nivel); end
        vectors++; if (bus.Resultado !== 8'd4) begin miscompares++; $display("FAIL overflow_resultado: got %0d expected 4", bus.Resultado); end
        pulse_limpar();
        vectors++; if (bus.Nivel !== 3'd0 || bus.Resultado !== 8'd0 || bus.Erro !== 1'b0) begin miscompares++; $display("FAIL limpar: got nivel %0d res %0d erro %b expected 0/0/0", bus.Nivel, bus.Resultado, bus.Erro); end
    endtask

    task automatic test_back_to_back();
        push(8'd9);
        push(8'd4);
        bus.Opcode  = OP_SOMA;
        bus.Entrada = 8'd77;
        bus.Enter   = 1'b1;
        bus.Operar  = 1'b1;
        step(1);
        vectors++; if (bus.Ocupado !== 1'b1 || bus.Nivel !== 3'd2) begin miscompares++; $display("FAIL simult_start: got ocupado %b nivel %0d expected 1/2", bus.Ocupado, bus.Nivel); end
        bus.Enter  = 1'b0;
        bus.Operar = 1'b0;
        step(3);
        vectors++; if (bus.Nivel !== 3'd1 || bus.Resultado !== 8'd13) begin miscompares++; $display("FAIL simult_end: got nivel %0d res %0d expected 1/13", bus.Nivel, bus.Resultado); end
        bus.Entrada = 8'd50;
        bus.Enter   = 1'b1;
        step(10);
        vectors++; if (bus.Nivel !== 3'd2) begin miscompares++; $display("FAIL enter_held_nivel: got %0d expected 2", bus.Nivel); end
        bus.Enter = 1'b0;
        step(1);
        vectors++; if (bus.Resultado !== 8'd50) begin miscompares++; $display("FAIL enter_held_resultado: got %0d expected 50", bus.Resultado); end
    endtask

    task automatic test_busy_events();
        bus.Opcode = OP_SUB;
        bus.Operar = 1'b1;
        step(1);
        bus.Entrada = 8'd99;
        bus.Enter   = 1'b1;
        step(3);
        vectors++; if (bus.Nivel !== 3'd1 || bus.Resultado !== 8'd219) begin miscompares++; $display("FAIL busy_enter_lost: got nivel %0d res %0d expected 1/219", bus.Nivel, bus.Resultado); end
        step(2);
        vectors++; if (bus.Nivel !== 3'd1) begin miscompares++; $display("FAIL busy_enter_late: got %0d expected 1", bus.Nivel); end
        bus.Enter  = 1'b0;
        bus.Operar = 1'b0;
        step(1);
        push(8'd3);
        bus.Opcode = OP_SOMA;
        bus.Operar = 1'b1;
        step(1);
        bus.Limpar = 1'b1;
        step(3);
        vectors++; if (bus.Nivel !== 3'd1 || bus.Resultado !== 8'd222) begin miscompares++; $display("FAIL busy_limpar_lost: got nivel %0d res %0d expected 1/222", bus.Nivel, bus.Resultado); end
        step(2);
        vectors++; if (bus.Nivel !== 3'd1) begin miscompares++; $display("FAIL busy_limpar_late: got %0d expected 1", bus.Nivel); end
        bus.Limpar = 1'b0;
        bus.Operar = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid_op();
        push(8'd5);
        bus.Opcode = OP_SOMA;
        bus.Operar = 1'b1;
        step(2);
        vectors++; if (bus.Ocupado !== 1'b1) begin miscompares++; $display("FAIL midop_busy: got %b expected 1", bus.Ocupado); end
        Reset_n = 1'b0;
        step(1);
        vectors++; if (bus.Nivel !== 3'd0 || bus.Ocupado !== 1'b0 || bus.Resultado !== 8'd0) begin miscompares++; $display("FAIL midop_reset: got nivel %0d ocupado %b res %0d expected 0/0/0", bus.Nivel, bus.Ocupado, bus.Resultado); end
        Reset_n    = 1'b1;
        bus.Operar = 1'b0;
        step(3);
        vectors++; if (bus.Nivel !== 3'd0 || bus.Ocupado !== 1'b0) begin miscompares++; $display("FAIL midop_no_partial: got nivel %0d ocupado %b expected 0/0", bus.Nivel, bus.Ocupado); end
    endtask

    task automatic test_base();
        bus.BaseSel = BASE_OCT;
        #1;
        vectors++; if (bus.Base !== BASE_DEC) begin miscompares++; $display("FAIL base_before_edge: got %b expected 00", bus.Base); end
        step(1);
        vectors++; if (bus.Base !== 2'b10) begin miscompares++; $display("FAIL base_oct: got %b expected 10", bus.Base); end
        bus.BaseSel = 2'b11;
        step(1);
        vectors++; if (bus.Base !== 2'b11) begin miscompares++; $display("FAIL base_11: got %b expected 11", bus.Base); end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        Reset_n      = 1'b0;
        bus.Entrada  = '0;
        bus.Enter    = 1'b0;
        bus.Operar   = 1'b0;
        bus.Limpar   = 1'b0;
        bus.Opcode   = '0;
        bus.BaseSel  = BASE_DEC;
        test_reset();
        test_push();
        test_operate_soma();
        test_sub_underflow();
        test_overflow_limpar();
        test_back_to_back();
        test_busy_events();
        test_reset_mid_op();
        test_base();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
